// File: rtl/ped_request_unit_if.sv
// Controller-side bundle for the pedestrian request unit: mode in, request and lamp/display out.
interface ped_request_unit_if;
  logic [1:0] mode;
  logic       req;
  logic       wait_lamp;
  logic       walk;
  logic [4:0] walk_remaining;

  modport master (
    output mode,
    input  req,
    input  wait_lamp,
    input  walk,
    input  walk_remaining
  );

  modport slave (
    input  mode,
    output req,
    output wait_lamp,
    output walk,
    output walk_remaining
  );
endinterface

// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end: synchronise, debounce, latch the press, and drive
// WAIT/WALK lamps plus the WALK countdown from the controller's mode.
module ped_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WALK_CYCLES     = 30,
  parameter int unsigned COOLDOWN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              btn,
  ped_request_unit_if.slave ctl
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} state_e;

  localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] WALK_LOAD = 5'(WALK_CYCLES - 1);
  localparam logic [3:0] COOL_LAST = 4'(COOLDOWN_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       s_q, s_d;
  logic       db_q, db_d;
  logic       db_prev_q, db_prev_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [3:0] ccnt_q, ccnt_d;
  logic [4:0] wr_q, wr_d;
  state_e     state_q, state_d;
  logic       press;
  logic       ped_mode;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
      ccnt_q    <= '0;
      wr_q      <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
      ccnt_q    <= ccnt_d;
      wr_q      <= wr_d;
      state_q   <= state_d;
    end
  end

  // Input path: the debounced level only moves after DEBOUNCE_CYCLES disagreeing samples in a row.
  always_comb begin
    sync1_d   = btn;
    s_d       = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    dcnt_d    = '0;
    if (s_q != db_q) begin
      if (dcnt_q == DEB_LAST) begin
        db_d = s_q;
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end
  end

  assign press    = db_q & ~db_prev_q;
  assign ped_mode = (ctl.mode == 2'd0);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      IDLE: begin
        if (ped_mode) begin
          state_d = SERVING;
          wr_d    = WALK_LOAD;
        end else if (press) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (ped_mode) begin
          state_d = SERVING;
          wr_d    = WALK_LOAD;
        end
      end
      SERVING: begin
        if (!ped_mode) begin
          state_d = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
          wr_d    = '0;
          ccnt_d  = '0;
        end else if (wr_q != '0) begin
          wr_d = wr_q - 5'd1;
        end
      end
      COOLDOWN: begin
        if (ped_mode) begin
          state_d = SERVING;
          wr_d    = WALK_LOAD;
        end else if (ccnt_q == COOL_LAST) begin
          state_d = IDLE;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // walk_remaining is only ever non-zero in SERVING, so it can be driven straight from the flop.
  assign ctl.req            = (state_q == PENDING);
  assign ctl.wait_lamp      = (state_q == PENDING);
  assign ctl.walk           = (state_q == SERVING);
  assign ctl.walk_remaining = wr_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit with a phase-level behavioural model checked every cycle.
module tb_ped_request_unit;
  localparam int DEB  = 4;
  localparam int WALK = 30;
  localparam int COOL = 2;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  logic btn   = 1'b0;
  bit   cmp_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ped_request_unit_if bus();

  ped_request_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .WALK_CYCLES    (WALK),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .btn  (btn),
    .ctl  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for service, 2 walking, 3 cooldown.
  bit m_s1, m_s2, m_db, m_db_old, m_press;
  bit s_hist[$];
  int m_phase = 0;
  int m_served = 0;
  int m_cool_left = 0;
  bit all_diff;

  initial forever begin
    @(posedge clk or negedge clr_n);
    if (!clr_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_db_old = 0;
      s_hist.delete();
      m_phase = 0; m_served = 0; m_cool_left = 0;
    end else begin
      m_press = m_db && !m_db_old;
      case (m_phase)
        0: if (bus.mode == 2'd0) begin m_phase = 2; m_served = 0; end
           else if (m_press) m_phase = 1;
        1: if (bus.mode == 2'd0) begin m_phase = 2; m_served = 0; end
        2: if (bus.mode != 2'd0) begin
             m_phase = (COOL == 0) ? 0 : 3;
             m_cool_left = COOL;
           end else m_served++;
        default: if (bus.mode == 2'd0) begin m_phase = 2; m_served = 0; end
           else begin
             m_cool_left--;
             if (m_cool_left == 0) m_phase = 0;
           end
      endcase
      m_db_old = m_db;
      s_hist.push_back(m_s2);
      if (s_hist.size() > DEB) void'(s_hist.pop_front());
      all_diff = (s_hist.size() == DEB);
      foreach (s_hist[i]) if (s_hist[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = !m_db;
        s_hist.delete();
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  function automatic int exp_wr();
    int r;
    r = WALK - 1 - m_served;
    if (m_phase != 2 || r < 0) return 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_req",  int'(bus.req),            (m_phase == 1) ? 1 : 0);
      chk("model_wait", int'(bus.wait_lamp),      (m_phase == 1) ? 1 : 0);
      chk("model_walk", int'(bus.walk),           (m_phase == 2) ? 1 : 0);
      chk("model_wrem", int'(bus.walk_remaining), exp_wr());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bus.mode = 2'd1;
    tick(2);
    cmp_en = 1'b1;
    clr_n = 1'b1;

    // 1: idle after reset
    tick(50);
    chk("t1_req",  int'(bus.req), 0);
    chk("t1_wait", int'(bus.wait_lamp), 0);
    chk("t1_walk", int'(bus.walk), 0);

    // 2: clean press, service, countdown, cooldown
    btn = 1'b1;
    tick(6);
    chk("t2_req_edge6", int'(bus.req), 0);
    tick(1);
    chk("t2_req_edge7", int'(bus.req), 1);
    chk("t2_wait_edge7", int'(bus.wait_lamp), 1);
    tick(5);
    chk("t2_req_held", int'(bus.req), 1);
    btn = 1'b0;
    bus.mode = 2'd0;
    tick(1);
    chk("t2_req_served", int'(bus.req), 0);
    chk("t2_walk_on", int'(bus.walk), 1);
    chk("t2_wrem_load", int'(bus.walk_remaining), 29);
    tick(40);
    chk("t2_wrem_sat", int'(bus.walk_remaining), 0);
    chk("t2_walk_held", int'(bus.walk), 1);
    bus.mode = 2'd1;
    tick(1);
    chk("t2_walk_off", int'(bus.walk), 0);
    chk("t2_wrem_clr", int'(bus.walk_remaining), 0);
    tick(5);

    // 3: glitches and a short pulse are rejected, a 4-cycle pulse is a press
    btn = 1'b1; tick(1); btn = 1'b0; tick(1);
    btn = 1'b1; tick(1); btn = 1'b0;
    tick(15);
    chk("t3_glitch", int'(bus.req), 0);
    btn = 1'b1; tick(3); btn = 1'b0;
    tick(15);
    chk("t3_short", int'(bus.req), 0);
    btn = 1'b1; tick(4); btn = 1'b0;
    tick(10);
    chk("t3_press", int'(bus.req), 1);

    // 4: presses during SERVING and COOLDOWN are dropped, first IDLE cycle is not
    bus.mode = 2'd0;
    tick(2);
    btn = 1'b1; tick(8); btn = 1'b0; tick(10);
    chk("t4_serving", int'(bus.walk), 1);
    btn = 1'b1;
    tick(5);
    bus.mode = 2'd1;
    btn = 1'b0;
    tick(15);
    chk("t4_cool_drop", int'(bus.req), 0);
    bus.mode = 2'd0;
    tick(3);
    btn = 1'b1;
    tick(3);
    bus.mode = 2'd1;
    tick(2);
    btn = 1'b0;
    tick(10);
    chk("t4_idle_press", int'(bus.req), 1);
    bus.mode = 2'd0; tick(3);
    bus.mode = 2'd1; tick(6);

    // 5: service without a request
    bus.mode = 2'd0;
    tick(1);
    chk("t5_walk", int'(bus.walk), 1);
    chk("t5_wrem", int'(bus.walk_remaining), 29);
    chk("t5_req", int'(bus.req), 0);
    tick(3);
    chk("t5_wrem_dec", int'(bus.walk_remaining), 26);
    bus.mode = 2'd2;
    tick(1);
    chk("t5_walk_off", int'(bus.walk), 0);
    tick(5);
    chk("t5_idle_req", int'(bus.req), 0);

    // 6: asynchronous reset while pending, button held through it
    btn = 1'b1;
    tick(7);
    chk("t6_pending", int'(bus.req), 1);
    @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    chk("t6_async_req", int'(bus.req), 0);
    chk("t6_async_wait", int'(bus.wait_lamp), 0);
    @(posedge clk);
    #2 clr_n = 1'b1;
    tick(6);
    chk("t6_req_edge6", int'(bus.req), 0);
    tick(1);
    chk("t6_req_edge7", int'(bus.req), 1);
    btn = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
